// File: rtl/bsg_and_arb_pkg.sv
// Shared constants and helpers for the round-robin bsg_and arbiter.
package bsg_and_arb_pkg;

  localparam int unsigned CntWidth = 16;
  localparam logic [CntWidth-1:0] CntSatVal = '1;

  // A tag must be at least one bit wide, even when only one index would exist.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_and.sv
// Bitwise AND of two equal-width operands.
module bsg_and #(
  parameter int width_p = 1
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] o
);

  assign o = a_i & b_i;

endmodule

// File: rtl/bsg_and_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module bsg_and_rr_pick
  import bsg_and_arb_pkg::*;
#(
  parameter int num_req_p = 4,
  localparam int tag_width_lp = tag_width(num_req_p)
) (
  input  logic [num_req_p-1:0]    req_i,
  input  logic [tag_width_lp-1:0] ptr_i,
  input  logic                    en_i,
  output logic [num_req_p-1:0]    grant_o,
  output logic [tag_width_lp-1:0] idx_o
);

  int   k;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < num_req_p; i++) begin
      k = (int'(ptr_i) + i) % num_req_p;
      if (en_i && !found && req_i[k]) begin
        found      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = k[tag_width_lp-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_and_rr_arbiter.sv
// Round-robin arbiter sharing one bsg_and among num_req_p requesters, with a
// one-entry tagged output buffer. Define BSG_AND_RR_ARBITER_GRANT_CNT_EN for per-requester grant counters.
module bsg_and_rr_arbiter
  import bsg_and_arb_pkg::*;
#(
  parameter int width_p   = 16,
  parameter int num_req_p = 4,
  localparam int tag_width_lp = tag_width(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p-1:0]           v_i,
  input  logic [num_req_p*width_p-1:0]   a_i,
  input  logic [num_req_p*width_p-1:0]   b_i,
  output logic [num_req_p-1:0]           ready_o,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  output logic [tag_width_lp-1:0]        tag_o,
  input  logic                           yumi_i
`ifdef BSG_AND_RR_ARBITER_GRANT_CNT_EN
  ,
  output logic [num_req_p*CntWidth-1:0]  grant_cnt_o
`endif
);

  logic                    v_q, v_d;
  logic [width_p-1:0]      data_q, data_d;
  logic [tag_width_lp-1:0] tag_q, tag_d;
  logic [tag_width_lp-1:0] ptr_q, ptr_d;

  logic                    free;
  logic [num_req_p-1:0]    grant;
  logic [tag_width_lp-1:0] pick_idx;
  logic                    xfer;
  logic [width_p-1:0]      a_sel, b_sel, and_res;

  // Gating with reset keeps ready_o low while reset is held.
  assign free = (~v_q | yumi_i) & reset_n_i;

  bsg_and_rr_pick #(.num_req_p(num_req_p)) pick (
    .req_i   (v_i),
    .ptr_i   (ptr_q),
    .en_i    (free),
    .grant_o (grant),
    .idx_o   (pick_idx)
  );

  assign xfer    = |grant;
  assign ready_o = grant;
  assign a_sel   = a_i[int'(pick_idx)*width_p +: width_p];
  assign b_sel   = b_i[int'(pick_idx)*width_p +: width_p];

  bsg_and #(.width_p(width_p)) and_dp (
    .a_i (a_sel),
    .b_i (b_sel),
    .o   (and_res)
  );

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    ptr_d  = ptr_q;
    if (xfer) begin
      v_d    = 1'b1;
      data_d = and_res;
      tag_d  = pick_idx;
      ptr_d  = (pick_idx == tag_width_lp'(num_req_p - 1)) ? '0 : pick_idx + 1'b1;
    end else if (yumi_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      ptr_q  <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      ptr_q  <= ptr_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;

`ifdef BSG_AND_RR_ARBITER_GRANT_CNT_EN
  logic [CntWidth-1:0] cnt_q [num_req_p];

  for (genvar k = 0; k < num_req_p; k++) begin : g_cnt
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt_q[k] <= '0;
      end else if (grant[k] && (cnt_q[k] != CntSatVal)) begin
        cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
    assign grant_cnt_o[k*CntWidth +: CntWidth] = cnt_q[k];
  end
`endif

  // Consumer may only take a result that is actually present.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);

endmodule

// File: tb/tb_bsg_and_rr_arbiter.sv
// Directed plus randomized bench for bsg_and_rr_arbiter against a spec-level reference model.
module tb_bsg_and_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      v_i;
  logic [N*W-1:0]    a_i, b_i;
  logic [N-1:0]      ready_o;
  logic              v_o;
  logic [W-1:0]      data_o;
  logic [TW-1:0]     tag_o;
  logic              yumi_i;
`ifdef BSG_AND_RR_ARBITER_GRANT_CNT_EN
  logic [N*16-1:0]   grant_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit       m_v;
  int       m_data;
  int       m_tag;
  int       m_ptr;
  int       m_cnt [N];

  always #5 clk = ~clk;

  bsg_and_rr_arbiter #(.width_p(W), .num_req_p(N)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .v_i       (v_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ready_o   (ready_o),
    .v_o       (v_o),
    .data_o    (data_o),
    .tag_o     (tag_o),
    .yumi_i    (yumi_i)
`ifdef BSG_AND_RR_ARBITER_GRANT_CNT_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_data = 0; m_tag = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // Winner index under the round-robin rule, or -1 if no grant this cycle.
  function automatic int winner();
    if (m_v && !yumi_i) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (v_i[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_i[k*W +: W] = a;
    b_i[k*W +: W] = b;
  endtask

  task automatic step();
    int w;
    logic [N-1:0] er;
    #1;
    w  = winner();
    er = (w < 0) ? '0 : (N'(1) << w);
    chk("ready_o", 32'(ready_o), 32'(er));
    @(posedge clk);
    if (w >= 0) begin
      m_data = int'(a_i[w*W +: W] & b_i[w*W +: W]);
      m_tag  = w;
      m_v    = 1;
      m_ptr  = (w + 1) % N;
      m_cnt[w]++;
    end else if (yumi_i) begin
      m_v = 0;
    end
    @(negedge clk);
    chk("v_o", 32'(v_o), 32'(m_v));
    chk("data_o", 32'(data_o), 32'(m_data));
    chk("tag_o", 32'(tag_o), 32'(m_tag));
`ifdef BSG_AND_RR_ARBITER_GRANT_CNT_EN
    for (int i = 0; i < N; i++)
      chk("grant_cnt", 32'(grant_cnt_o[i*16 +: 16]), (m_cnt[i] > 65535) ? 32'hFFFF : 32'(m_cnt[i]));
`endif
  endtask

  initial begin
    logic [W-1:0] d_hold;
    logic [TW-1:0] t_hold;

    rst_n = 1'b0; v_i = '0; a_i = '0; b_i = '0; yumi_i = 1'b0;
    model_reset();

    // Reset state: ready stays low even with requests pending
    @(negedge clk);
    v_i = 4'b1111;
    #1;
    chk("rst_v_o", 32'(v_o), 32'h0);
    chk("rst_data_o", 32'(data_o), 32'h0);
    chk("rst_tag_o", 32'(tag_o), 32'h0);
    chk("rst_ready_o", 32'(ready_o), 32'h0);
    rst_n = 1'b1;

    // Single request from requester 2
    v_i = 4'b0100;
    set_op(2, 16'hF0F0, 16'h3C3C);
    #1 chk("single_ready", 32'(ready_o), 32'h4);
    step();
    chk("single_data", 32'(data_o), 32'h3030);
    chk("single_tag", 32'(tag_o), 32'h2);

    // Rotation: ptr is 3 after granting 2, so tags run 3,0,1,2,3,0
    v_i = 4'b1111;
    yumi_i = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h1111 * (i + 1)), 16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rot_tag", 32'(tag_o), 32'((3 + i) % 4));
      chk("rot_v", 32'(v_o), 32'h1);
    end

    // Backpressure for 5 cycles, then release
    v_i = 4'b0011;
    yumi_i = 1'b0;
    d_hold = data_o;
    t_hold = tag_o;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ready", 32'(ready_o), 32'h0);
      chk("bp_data", 32'(data_o), 32'(d_hold));
      chk("bp_tag", 32'(tag_o), 32'(t_hold));
    end
    yumi_i = 1'b1;
    step();

    // Pointer wrap/skip: drive ptr to 3, then 4'b0101 grants 0 then 2
    v_i = 4'b0100;
    step();
    v_i = 4'b0101;
    #1 chk("wrap_ready0", 32'(ready_o), 32'h1);
    step();
    chk("wrap_tag0", 32'(tag_o), 32'h0);
    #1 chk("wrap_ready2", 32'(ready_o), 32'h4);
    step();
    chk("wrap_tag2", 32'(tag_o), 32'h2);

    // Async reset mid-flight with 16'h00FF from requester 1 buffered
    v_i = 4'b0010;
    set_op(1, 16'h00FF, 16'hFFFF);
    step();
    chk("pre_rst_data", 32'(data_o), 32'h00FF);
    chk("pre_rst_tag", 32'(tag_o), 32'h1);
    v_i = 4'b0000;
    yumi_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_v_o", 32'(v_o), 32'h0);
    chk("async_data_o", 32'(data_o), 32'h0);
    chk("async_tag_o", 32'(tag_o), 32'h0);
    rst_n = 1'b1;
    model_reset();
    v_i = 4'b1111;
    #1 chk("post_rst_ready", 32'(ready_o), 32'h1);
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v_i    = N'($urandom);
      a_i    = {$urandom, $urandom};
      b_i    = {$urandom, $urandom};
      yumi_i = m_v ? 1'($urandom) : 1'b0;
      step();
    end

`ifdef BSG_AND_RR_ARBITER_GRANT_CNT_EN
    // Drive requester 1 past counter saturation
    v_i = 4'b0010;
    set_op(1, 16'hA5A5, 16'h0F0F);
    for (int i = 0; i < 70000; i++) begin
      yumi_i = m_v;
      step();
    end
    chk("sat_cnt1", 32'(grant_cnt_o[16 +: 16]), 32'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_and_rr_arbiter.md
Name: bsg_and_rr_arbiter

Overview:
- Shares one `bsg_and` bitwise-AND datapath (`width_p` wide) among `num_req_p` requesters.
- Round-robin arbitration selects one requester's operand pair per cycle.
- Result is registered in a one-entry output buffer, tagged with the winning requester index.
- Sits between operand producers and a single downstream consumer using a valid/yumi handshake.

Parameters:
- width_p, 16, operand/result width in bits.
- num_req_p, 4, number of requesters; legal range 2..16.
- tag_width_lp, derived as max(1, clog2(num_req_p)), width of tag_o (localparam).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- v_i  in  num_req_p  per-requester operand valid.
- a_i  in  num_req_p*width_p  operand A; requester k occupies bits [k*width_p +: width_p].
- b_i  in  num_req_p*width_p  operand B; same packing as a_i.
- ready_o  out  num_req_p  one-hot-or-zero grant; transfer when v_i[k] & ready_o[k].
- v_o  out  1  output buffer holds a valid result.
- data_o  out  width_p  a & b of the granted requester.
- tag_o  out  tag_width_lp  index of the requester that produced data_o.
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1.

Behaviour:
- Reset (reset_n_i=0, asynchronous): v_o=0, data_o=0, tag_o=0, priority pointer=0. ready_o is 0 while reset is asserted.
- Deassertion is synchronized externally. The first active edge after release is a normal cycle.
- Buffer free condition: free = ~v_o | yumi_i. This allows a same-cycle dequeue plus enqueue with no bubble.
- Grant:
  - When free=1, ready_o[k]=1 for exactly one k: the first requester with v_i=1 searching ptr, ptr+1, …, wrapping mod num_req_p.
  - When free=0 or no v_i is set, ready_o=0.
  - ready_o depends combinationally on v_i, v_o and yumi_i. Requesters must not derive v_i from ready_o.
- On a transfer to requester k at edge t:
  - data_o = a_i[k] & b_i[k], computed via the `bsg_and` instance.
  - tag_o = k, v_o = 1, all visible from cycle t+1.
  - ptr = (k+1) mod num_req_p.
  - Latency is exactly 1 cycle.
- Pointer is unchanged on cycles with no transfer.
- Dequeue without enqueue (yumi_i=1, no transfer): v_o goes to 0. data_o and tag_o hold their last values.
- Backpressure (v_o=1, yumi_i=0): data_o, tag_o and v_o hold, and ready_o=0.
- Fairness: with all requesters continuously valid and yumi_i=1 every cycle, grants rotate 0,1,…,N-1,0. No requester waits more than num_req_p-1 grants.
- yumi_i=1 while v_o=0 is illegal. The design ignores it (free is already 1). An assertion flags it in simulation.
- Reset asserted mid-operation: the buffered result is discarded, v_o drops to 0 immediately, and ptr returns to 0.

Optional Feature:
- Macro: BSG_AND_RR_ARBITER_GRANT_CNT_EN.
- When defined:
  - Adds output port grant_cnt_o, num_req_p*16 bits wide.
  - One 16-bit saturating counter per requester, incremented on each transfer for that requester.
  - Counters hold at 16'hFFFF and reset to 0 on reset_n_i.
- When undefined: no port, no counters. Behaviour is otherwise identical.

Decomposition:
- Package `bsg_and_arb_pkg`:
  - function computing tag width (max(1, clog2(n))).
  - constant for counter width (16).
  - constant for counter saturation value.
- Sub-module `bsg_and_rr_pick`: combinational round-robin picker.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and encoded index.
- Datapath: existing `bsg_and` instantiated once on the muxed operands. No new datapath module.

Test Plan:
- Reset then single request: N=4, W=16; v_i=4'b0100, a_i[2]=16'hF0F0, b_i[2]=16'h3C3C, yumi_i=1 → ready_o=4'b0100; next cycle v_o=1, data_o=16'h3030, tag_o=2.
- Rotation: v_i=4'b1111 held, yumi_i=1 every cycle → tag_o sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure: v_o=1, yumi_i=0 for 5 cycles, v_i=4'b0011 → ready_o=0 and data_o/tag_o stable for all 5 cycles. On yumi_i=1, same-cycle grant to ptr-priority requester.
- Pointer wrap/skip: ptr=3, v_i=4'b0101 → grant requester 0, then ptr=1. Next cycle the grant goes to requester 2.
- Async reset mid-flight: v_o=1 holding 16'h00FF, tag 1; pulse reset_n_i low between edges → v_o=0 and data_o=0 before the next edge. After release, v_i=4'b1111 grants requester 0.
- GRANT_CNT_EN build: 70000 grants to requester 1 → grant_cnt_o[1]=16'hFFFF (saturated); other counters match their actual grant counts.
